// File: rtl/peripheral_bfm_master_generic_apb4_if.sv
// rtl/peripheral_bfm_master_generic_apb4_if.sv - single-beat AXI4-Lite-style bus between initiator and slave
interface peripheral_bfm_master_generic_apb4_if;
    logic [3:0]  awid;
    logic [31:0] awadr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wrdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wrdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wrdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/peripheral_bfm_master_generic_apb4.sv
// rtl/peripheral_bfm_master_generic_apb4.sv - command-driven single-beat bus initiator with phase timeout
module peripheral_bfm_master_generic_apb4 #(
    parameter logic [3:0]  ID_VALUE = 4'h0,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    peripheral_bfm_master_generic_apb4_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP
    } state_t;

    // Last counter value at which a still-pending phase is abandoned; the
    // counter holds the number of cycles already spent in the phase.
    localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] tcnt;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        arvalid_q;
    logic        bready_q;
    logic        rready_q;
    logic [31:0] awadr_q;
    logic [31:0] araddr_q;
    logic [31:0] wrdata_q;
    logic [3:0]  wstrb_q;

    logic        in_phase;
    logic        phase_done;
    logic        tmo_hit;
    logic        tmo_abort;
    logic        unused_inputs;

    // Fixed single-beat attributes
    assign bus.awid    = ID_VALUE;
    assign bus.wid     = ID_VALUE;
    assign bus.arid    = ID_VALUE;
    assign bus.awlen   = 4'h0;
    assign bus.arlen   = 4'h0;
    assign bus.awsize  = 3'b010;
    assign bus.arsize  = 3'b010;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.arlock  = 2'b00;
    assign bus.awcache = 4'h0;
    assign bus.arcache = 4'h0;
    assign bus.awprot  = 3'h0;
    assign bus.arprot  = 3'h0;

    assign bus.awvalid = awvalid_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.wlast   = wvalid_q;
    assign bus.arvalid = arvalid_q;
    assign bus.bready  = bready_q;
    assign bus.rready  = rready_q;
    assign bus.awadr   = awadr_q;
    assign bus.araddr  = araddr_q;
    assign bus.wrdata  = wrdata_q;
    assign bus.wstrb   = wstrb_q;

    assign unused_inputs = ^{bus.bid, bus.rid, bus.rlast};

    assign tmo_hit   = (TIMEOUT != 0) && (tcnt >= TMO_LAST);
    assign tmo_abort = in_phase & ~phase_done & tmo_hit;

    // Decide whether the current bus phase finishes on this edge
    always_comb begin
        in_phase   = 1'b0;
        phase_done = 1'b0;
        case (state)
            S_WR_REQ: begin
                in_phase   = 1'b1;
                phase_done = (~awvalid_q | bus.awready) & (~wvalid_q | bus.wready);
            end
            S_WR_RESP: begin
                in_phase   = 1'b1;
                phase_done = bus.bvalid;
            end
            S_RD_REQ: begin
                in_phase   = 1'b1;
                phase_done = bus.arready;
            end
            S_RD_DATA: begin
                in_phase   = 1'b1;
                phase_done = bus.rvalid;
            end
            default: begin
                in_phase   = 1'b0;
                phase_done = 1'b0;
            end
        endcase
    end

    // Transaction sequencer with registered bus and response outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= S_IDLE;
            tcnt        <= 32'd0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            awadr_q     <= 32'd0;
            araddr_q    <= 32'd0;
            wrdata_q    <= 32'd0;
            wstrb_q     <= 4'h0;
        end else begin
            if (tcnt != '1) begin
                tcnt <= tcnt + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        tcnt        <= 32'd0;
                        if (cmd_write) begin
                            awadr_q   <= cmd_addr;
                            wrdata_q  <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= S_WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state     <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (bus.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (bus.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (phase_done) begin
                        bready_q <= 1'b1;
                        tcnt     <= 32'd0;
                        state    <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bus.bvalid) begin
                        bready_q  <= 1'b0;
                        rsp_resp  <= bus.bresp;
                        rsp_rdata <= 32'd0;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        tcnt      <= 32'd0;
                        state     <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (bus.rvalid) begin
                        rready_q  <= 1'b0;
                        rsp_rdata <= bus.rdata;
                        rsp_resp  <= bus.rresp;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase

            // A stalled phase is abandoned with SLVERR and a timeout flag
            if (tmo_abort) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                bready_q    <= 1'b0;
                rready_q    <= 1'b0;
                rsp_timeout <= 1'b1;
                rsp_resp    <= 2'b10;
                rsp_rdata   <= 32'd0;
                rsp_valid   <= 1'b1;
                state       <= S_RSP;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_bfm_master_generic_apb4.sv
// tb/tb_peripheral_bfm_master_generic_apb4.sv - self-checking bench for the bus initiator
module tb_peripheral_bfm_master_generic_apb4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          b_dly;
        int          r_dly;
        int          rsp_dly;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        logic        e_tmo;
        int          e_lat;
        int          e_aw;
        int          e_w;
        int          e_ar;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          lat;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    peripheral_bfm_master_generic_apb4_if bus();

    peripheral_bfm_master_generic_apb4 #(
        .ID_VALUE (4'h5),
        .TIMEOUT  (8)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .bus         (bus)
    );

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];

    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0, rsp_dly = 0;
    logic [1:0]  s_resp = 2'b00;
    logic [31:0] s_rdata = 32'd0;
    logic [31:0] cur_addr = 32'd0, cur_wdata = 32'd0;
    logic [3:0]  cur_strb = 4'h0;

    int ncyc = 0, acc_cyc = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, rs_cnt = 0;
    int aw_hi = 0, w_hi = 0, ar_hi = 0, bus_err = 0;
    logic rsp_seen = 1'b0;

    vec_t vt[10];

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Slave model, response scoreboard and bus monitor; acts on falling edges
    initial begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = 4'h0;
        bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00; bus.rid = 4'h0; bus.rlast = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge aclk);
            ncyc++;
            if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin bus.awready = 1'b0; aw_cnt = 0; end
            if (bus.wvalid) begin bus.wready = (w_cnt >= w_dly); w_cnt++; end
            else begin bus.wready = 1'b0; w_cnt = 0; end
            if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin bus.arready = 1'b0; ar_cnt = 0; end
            if (bus.bready) begin bus.bvalid = (b_cnt >= b_dly); bus.bresp = s_resp; b_cnt++; end
            else begin bus.bvalid = 1'b0; b_cnt = 0; end
            if (bus.rready) begin bus.rvalid = (r_cnt >= r_dly); bus.rdata = s_rdata; bus.rresp = s_resp; r_cnt++; end
            else begin bus.rvalid = 1'b0; r_cnt = 0; end
            bus.rlast = bus.rvalid;
            if (rsp_valid) begin rsp_ready = (rs_cnt >= rsp_dly); rs_cnt++; end
            else begin rsp_ready = 1'b0; rs_cnt = 0; end

            if (bus.awvalid) aw_hi++;
            if (bus.wvalid) w_hi++;
            if (bus.arvalid) ar_hi++;
            if (bus.wlast != bus.wvalid) bus_err++;
            if (bus.awvalid && bus.awadr != cur_addr) bus_err++;
            if (bus.wvalid && (bus.wrdata != cur_wdata || bus.wstrb != cur_strb)) bus_err++;
            if (bus.arvalid && bus.araddr != cur_addr) bus_err++;
            if (bus.bready && (bus.awvalid || bus.wvalid)) bus_err++;
            if (bus.rready && bus.arvalid) bus_err++;
            if (rsp_valid && cmd_ready) bus_err++;

            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1'b1;
                if (exp_q.size() > 0 && exp_q[0].lat != 0)
                    chk("latency", 32'(ncyc - acc_cyc), 32'(exp_q[0].lat));
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc = ncyc;
                aw_hi = 0; w_hi = 0; ar_hi = 0; bus_err = 0;
            end
        end
    end

    task automatic start_cmd(input vec_t v);
        exp_t e;
        int n;
        aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly;
        b_dly = v.b_dly; r_dly = v.r_dly; rsp_dly = v.rsp_dly;
        s_resp = v.sresp; s_rdata = v.srdata;
        cur_addr = v.addr; cur_wdata = v.wdata; cur_strb = v.strb;
        e.rdata = v.e_rdata; e.resp = v.e_resp; e.tmo = v.e_tmo; e.lat = v.e_lat;
        exp_q.push_back(e);
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge aclk); #1; n++; end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        cmd_valid = 1'b1;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input vec_t v);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge aclk); #1; n++; end
        chk("rsp_wait", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
        chk("aw_cycles", 32'(aw_hi), 32'(v.e_aw));
        chk("w_cycles", 32'(w_hi), 32'(v.e_w));
        chk("ar_cycles", 32'(ar_hi), 32'(v.e_ar));
        chk("bus_rules", 32'(bus_err), 32'd0);
    endtask

    initial begin
        vec_t vc;
        int n;
        areset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_wstrb = 4'h0;

        //            wr    addr        wdata         strb  aw w ar b r rs sresp  srdata        e_rdata       e_resp e_tmo lat aw w ar
        vt[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 3,  1, 1, 0};
        vt[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 3,  0, 0, 1};
        vt[2] = '{1'b1, 32'h24, 32'h12345678, 4'h3, 4, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 7,  5, 1, 0};
        vt[3] = '{1'b0, 32'h30, 32'h0,        4'h0, 0, 0, 255, 0, 0, 0, 2'b00, 32'hAAAA5555, 32'h0,       2'b10, 1'b1, 9,  0, 0, 8};
        vt[4] = '{1'b1, 32'h34, 32'h00FF00FF, 4'h5, 0, 0, 0, 0, 0, 3, 2'b10, 32'h0,        32'h0,        2'b10, 1'b0, 3,  1, 1, 0};
        vt[5] = '{1'b0, 32'h38, 32'h0,        4'h0, 0, 0, 0, 0, 2, 0, 2'b01, 32'hCAFEF00D, 32'hCAFEF00D, 2'b01, 1'b0, 5,  0, 0, 1};
        vt[6] = '{1'b1, 32'h3C, 32'h11112222, 4'hF, 0, 0, 0, 255, 0, 0, 2'b00, 32'h0,       32'h0,        2'b10, 1'b1, 10, 1, 1, 0};
        vt[7] = '{1'b0, 32'h44, 32'h0,        4'h0, 0, 0, 0, 0, 0, 1, 2'b00, 32'h0BADF00D, 32'h0BADF00D, 2'b00, 1'b0, 3,  0, 0, 1};
        vt[8] = '{1'b1, 32'h48, 32'h55AA55AA, 4'h8, 1, 3, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 6,  2, 4, 0};
        vt[9] = '{1'b1, 32'h4C, 32'h99999999, 4'hF, 8, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b10, 1'b1, 9,  8, 1, 0};

        // Reset state and fixed attributes
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_handshakes", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}), 32'd0);
        chk("rst_addr_data", bus.awadr | bus.araddr | bus.wrdata | 32'(bus.wstrb), 32'd0);
        chk("rst_rsp", rsp_rdata | 32'({rsp_resp, rsp_timeout}), 32'd0);
        chk("ids_lens", 32'({bus.awid, bus.wid, bus.arid, bus.awlen, bus.arlen}), 32'h0005_5500);
        chk("attrs", 32'({bus.awsize, bus.arsize, bus.awburst, bus.awlock, bus.arlock,
                          bus.awcache, bus.arcache, bus.awprot, bus.arprot}), 32'h0124_0000);
        areset = 1'b0;
        @(posedge aclk); #1;

        for (int i = 0; i < 10; i++) begin
            start_cmd(vt[i]);
            finish_cmd(vt[i]);
        end

        // Reset while waiting for the write response: abort with no response
        vc = vt[0];
        vc.addr = 32'h80;
        vc.b_dly = 255;
        start_cmd(vc);
        n = 0;
        while (!bus.bready && n < 20) begin @(posedge aclk); #1; n++; end
        chk("reach_wr_resp", 32'(bus.bready), 32'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("rst_mid_bready", 32'(bus.bready), 32'd0);
        chk("rst_mid_valids", 32'({bus.awvalid, bus.wvalid, rsp_valid}), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge aclk); #1;
        chk("rst_mid_no_rsp", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        areset = 1'b0;
        @(posedge aclk); #1;

        start_cmd(vt[0]);
        finish_cmd(vt[0]);
        start_cmd(vt[1]);
        finish_cmd(vt[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peripheral_bfm_master_generic_apb4.md
Name: peripheral_bfm_master_generic_apb4

Overview:
- Command-driven bus initiator: the requesting end of the AXI4-Lite-style single-beat bus used by the generic slave BFM and peripherals.
- Accepts one read or write command at a time on a simple valid/ready command port.
- Drives the address, write-data and response channels, then returns the read data or write status on a response port.
- Sits in validation benches between the test sequencer and the slave under test; synthesizable, with a per-phase handshake timeout.

Parameters:
ID_VALUE, 4'h0, constant driven on awid/wid/arid.
TIMEOUT, 256, max cycles waited in any bus phase before abort; 0 disables timeout.

Ports:
aclk  input  1  clock, rising edge.
areset  input  1  asynchronous reset, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  block idle, command accepted when cmd_valid&cmd_ready.
cmd_write  input  1  1=write, 0=read.
cmd_addr  input  32  byte address.
cmd_wdata  input  32  write data.
cmd_wstrb  input  4  write byte strobes.
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumed.
rsp_rdata  output  32  read data (0 for writes).
rsp_resp  output  2  captured bresp/rresp, or 2'b10 on timeout.
rsp_timeout  output  1  phase aborted by timeout.
awid, wid, arid  output  4 each  = ID_VALUE.
awadr / araddr  output  32 each  write / read address.
awlen, arlen  output  4 each  = 0 (single beat).
awsize, arsize  output  3 each  = 3'b010.
awburst  output  2  = 2'b01.
awlock, arlock  output  2 each  = 0.
awcache, arcache  output  4 each  = 0.
awprot, arprot  output  3 each  = 0.
awvalid, awready  output, input  1 each  write address handshake.
wrdata, wstrb  output  32, 4  write data, strobes.
wlast  output  1  = wvalid (single beat).
wvalid, wready  output, input  1 each  write data handshake.
bid  input  4  ignored.
bresp  input  2  write response.
bvalid, bready  input, output  1 each  write response handshake.
rid  input  4  ignored.
rdata, rresp  input  32, 2  read data, read response.
rlast  input  1  ignored.
rvalid, rready  input, output  1 each  read data handshake.

Behaviour:
- Reset (async, immediate): state IDLE; all valid/ready outputs 0 except cmd_ready=1; awadr, araddr, wrdata, wstrb, rsp_rdata, rsp_resp = 0; rsp_timeout=0; timeout counter=0.
- cmd_ready=1 only in IDLE (Moore output).
- Address, data and strobes are registered on command acceptance and held stable until the channel handshake completes.
- A channel handshake completes on a rising edge with valid&ready both high.
- State transitions:
  - IDLE -> WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0) on acceptance.
  - WR_REQ: awvalid and wvalid both rise the cycle after acceptance. Each drops independently after its own handshake. Simultaneous completion is allowed. Move to WR_RESP once both have completed.
  - WR_RESP: bready=1. On bvalid: capture bresp into rsp_resp, set rsp_rdata=0, go RSP.
  - RD_REQ: arvalid=1 until arready; go RD_DATA.
  - RD_DATA: rready=1. On rvalid: capture rdata/rresp, go RSP.
  - RSP: rsp_valid=1, held with rsp_* stable until rsp_ready; then IDLE. rsp_ready may be high on the first RSP cycle, giving a 1-cycle response.
- Minimum latency, acceptance to rsp_valid, with always-ready slave and same-cycle responses: write 3 cycles, read 3 cycles.
- Back-to-back: the next command is accepted the cycle after leaving RSP; no overlap of transactions.
- Timeout counter:
  - Cleared on entry to each of WR_REQ, WR_RESP, RD_REQ, RD_DATA; increments each cycle spent in the phase.
  - When it reaches TIMEOUT: deassert all bus valids/readies, set rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, go RSP.
  - Saturates; never wraps.
- rsp_timeout is cleared when the next command is accepted.
- Ignored inputs: bid, rid, rlast are not checked.
- A bvalid/rvalid arriving outside its wait state is ignored; bready/rready stay 0 there.
- Reset mid-transaction aborts immediately with no response issued; outputs return to reset values on the same assertion.

Test Plan:
- Always-ready slave, write addr 0x10, data 0xDEADBEEF, strb 4'hF -> awadr=0x10, wrdata=0xDEADBEEF, wlast=1 for one cycle; rsp_valid 3 cycles after acceptance with rsp_resp=0, rsp_timeout=0.
- Read back addr 0x10, slave returns rdata 0xDEADBEEF, rresp 0 -> rsp_rdata=0xDEADBEEF, rsp_resp=0.
- awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles with awadr stable; bready asserted only after both handshakes complete.
- TIMEOUT=8, slave never asserts arready -> arvalid high exactly 8 cycles, then rsp_valid with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
- Slave returns bresp=2'b10, rsp_ready held low 3 cycles -> rsp_valid held 3+ cycles with rsp_resp=2'b10 stable; cmd_ready=0 throughout, 1 the cycle after rsp_ready.
- areset asserted during WR_RESP -> bready, rsp_valid, awvalid, wvalid drop immediately and cmd_ready=1; next command completes normally.
